serdesphy_rx_aligner: RTL
=========================

// Module: serdesphy_rx_aligner
// PURPOSE
//  Consumes the recovered serial bitstream (rx_serial_data/rx_serial_valid) from the PMA deserializer on clk_240m_rx.
//  Hunts for the framing sync word, confirms it over several frames, then packs payload bits into 4-bit nibbles for the RX FIFO.
//  Drives rx_aligned and sync error status to the PCS status/CSR logic.
//  Frame on the wire: SYNC_W-bit sync word, then FRAME_LEN payload nibbles; MSB first.
// PARAMETERS
//  SYNC_W      8      sync word width in bits (4..16)
//  SYNC_WORD   8'hBC  sync pattern, transmitted MSB first
//  FRAME_LEN   4      payload nibbles per frame (1..64)
//  LOCK_HITS   3      consecutive good syncs in VERIFY needed to enter LOCKED (1..15)
//  MISS_LIMIT  4      consecutive bad syncs in LOCKED that force HUNT (1..15)
// PORTS
//  clk_240m_rx      in   1  RX recovered-domain clock
//  rst              in   1  synchronous, active-high reset
//  rx_serial_data   in   1  serial bit from PMA
//  rx_serial_valid  in   1  bit qualifier; all state frozen when low
//  align_en         in   1  0: hold in HUNT, no output
//  align_rst        in   1  synchronous re-hunt request (CSR rx_align_rst)
//  rx_nibble        out  4  packed payload nibble; first received bit in [3]
//  rx_nibble_valid  out  1  one-cycle strobe qualifying rx_nibble
//  rx_aligned       out  1  high only in LOCKED
//  sync_miss        out  1  one-cycle strobe on each bad sync in LOCKED
//  sync_err_cnt     out  8  saturating count of LOCKED sync misses
// BEHAVIOUR
//  Reset (rst or align_rst): state=HUNT, shift reg, bit/hit/miss counters=0; all outputs 0. rst and align_rst together: same result.
//  Sampling: a bit counts only in a cycle with rx_serial_valid=1. Window = {sr[SYNC_W-2:0], rx_serial_data}; match = (window==SYNC_WORD).
//  All outputs are registered; a strobe appears the cycle after the bit that caused it.
//  HUNT: shift every valid bit; on match -> VERIFY, hits=1, bit_cnt=0. align_en=0 forces and holds HUNT.
//  VERIFY: count FRAME_LEN*4 payload bits (no output), then SYNC_W sync bits; on last sync bit:
//    match -> hits++, hits==LOCK_HITS -> LOCKED, miss=0; else stay VERIFY with bit_cnt=0.
//    mismatch -> HUNT, hits=0 (no re-check of the current window in that cycle).
//  LOCKED: every 4th payload bit -> rx_nibble_valid=1 with assembled nibble. On last sync bit:
//    match -> miss=0; mismatch -> sync_miss pulse, sync_err_cnt++ (saturate at 8'hFF), miss++;
//    miss==MISS_LIMIT -> HUNT, rx_aligned falls next cycle. Frame timing is kept across misses (no re-slip).
//  bit_cnt wraps at SYNC_W+FRAME_LEN*4-1 -> 0; width $clog2(SYNC_W+FRAME_LEN*4).
//  Payload nibble emitted in the same frame as a later miss is still delivered (no retraction).
//  align_en falling in LOCKED: -> HUNT next cycle, rx_aligned=0, partial nibble discarded.
//  sync_err_cnt cleared only by rst/align_rst; LOCKED->HUNT via misses does not clear it.
//  rx_serial_valid gaps of any length: no state/counter change, no strobes.
// STRUCTURE
//  serdesphy_pkg: aligner state enum (HUNT/VERIFY/LOCKED), default SYNC_WORD, frame-length constants shared with TX framer.
//  Single module; no sub-module (sync compare and nibble pack are a few lines each).
// TESTING (defaults: SYNC=8'hBC, FRAME_LEN=4, LOCK_HITS=3, MISS_LIMIT=4)
//  1. 3 frames BC+16'h1234 contiguous -> rx_aligned high 1 cycle after 3rd sync; frame 4 payload 16'h5678 -> nibbles 5,6,7,8.
//  2. Stream offset by 3 junk bits, payload containing 8'hBC mid-frame -> no LOCKED until true sync period confirmed.
//  3. LOCKED, corrupt 4 consecutive syncs -> 4 sync_miss pulses, sync_err_cnt=4, rx_aligned low after 4th; 3 bad + 1 good -> stays locked.
//  4. rx_serial_valid toggled 1-of-3 cycles through lock sequence -> identical nibble sequence to test 1.
//  5. align_rst pulse mid-frame in LOCKED -> next cycle rx_aligned=0, sync_err_cnt=0, relock after 3 frames.
//  6. 300 consecutive bad syncs while relocking each time -> sync_err_cnt saturates at 8'hFF, no wrap.

Source files
------------

// File: rtl/serdesphy_pkg.sv
// ----------------------------------------------------------------------------
// serdesphy_pkg
// Shared definitions for the SerDes PHY framing logic (RX aligner, TX framer).
//   align_state_t      : RX aligner hunt/verify/locked states
//   DEFAULT_SYNC_*     : default framing sync word and its width
//   DEFAULT_FRAME_LEN  : payload nibbles per frame
//   DEFAULT_LOCK_HITS  : good syncs needed to declare lock
//   DEFAULT_MISS_LIMIT : bad syncs tolerated in lock before re-hunting
//   frame_bits()       : total wire bits per frame (sync + payload)
// ----------------------------------------------------------------------------
package serdesphy_pkg;

    typedef enum logic [1:0] {
        ALIGN_HUNT   = 2'd0,
        ALIGN_VERIFY = 2'd1,
        ALIGN_LOCKED = 2'd2
    } align_state_t;

    localparam int         NIBBLE_W           = 4;
    localparam int         ERR_CNT_W          = 8;
    localparam int         DEFAULT_SYNC_W     = 8;
    localparam logic [7:0] DEFAULT_SYNC_WORD  = 8'hBC;
    localparam int         DEFAULT_FRAME_LEN  = 4;
    localparam int         DEFAULT_LOCK_HITS  = 3;
    localparam int         DEFAULT_MISS_LIMIT = 4;

    // Number of serial bits in one frame: the sync word followed by the
    // payload nibbles.
    function automatic int frame_bits(input int sync_w, input int frame_len);
        return sync_w + frame_len * NIBBLE_W;
    endfunction

endpackage

// File: rtl/serdesphy_rx_aligner.sv
// ----------------------------------------------------------------------------
// serdesphy_rx_aligner
// Finds the framing sync word in the recovered serial bitstream, confirms it
// over several frames, then packs payload bits (MSB first) into nibbles.
//
// Ports
//   clk_240m_rx      in   RX recovered-domain clock
//   rst              in   synchronous active-high reset
//   rx_serial_data   in   serial bit from the PMA deserializer
//   rx_serial_valid  in   bit qualifier; everything is frozen while low
//   align_en         in   0 holds the aligner in HUNT with no output
//   align_rst        in   synchronous re-hunt request (same effect as rst)
//   rx_nibble        out  packed payload nibble, first received bit in [3]
//   rx_nibble_valid  out  one-cycle strobe qualifying rx_nibble
//   rx_aligned       out  high only while LOCKED
//   sync_miss        out  one-cycle strobe per bad sync while LOCKED
//   sync_err_cnt     out  saturating count of sync misses while LOCKED
// ----------------------------------------------------------------------------
module serdesphy_rx_aligner
    import serdesphy_pkg::*;
#(
    parameter int                SYNC_W     = DEFAULT_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int                FRAME_LEN  = DEFAULT_FRAME_LEN,
    parameter int                LOCK_HITS  = DEFAULT_LOCK_HITS,
    parameter int                MISS_LIMIT = DEFAULT_MISS_LIMIT
) (
    input  logic                 clk_240m_rx,
    input  logic                 rst,
    input  logic                 rx_serial_data,
    input  logic                 rx_serial_valid,
    input  logic                 align_en,
    input  logic                 align_rst,
    output logic [NIBBLE_W-1:0]  rx_nibble,
    output logic                 rx_nibble_valid,
    output logic                 rx_aligned,
    output logic                 sync_miss,
    output logic [ERR_CNT_W-1:0] sync_err_cnt
);

    localparam int               FRAME_BITS   = frame_bits(SYNC_W, FRAME_LEN);
    localparam int               PAYLOAD_BITS = FRAME_LEN * NIBBLE_W;
    localparam int               CNT_W        = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] PAYLOAD_END  = CNT_W'(PAYLOAD_BITS);
    localparam logic [3:0]       LOCK_HITS_C  = 4'(LOCK_HITS);
    localparam logic [3:0]       MISS_LIMIT_C = 4'(MISS_LIMIT);

    align_state_t         state, state_next;
    logic [SYNC_W-2:0]    sr, sr_next;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_next, bit_cnt_inc;
    logic [3:0]           hits, hits_next, hits_inc;
    logic [3:0]           miss, miss_next, miss_inc;
    logic [SYNC_W-1:0]    window;
    logic                 match;
    logic                 at_sync_end;
    logic                 at_nibble_end;
    logic [NIBBLE_W-1:0]  nibble_next;
    logic                 nibble_valid_next;
    logic                 aligned_next;
    logic                 sync_miss_next;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    // Only SYNC_W-1 history bits are stored; the current bit completes the
    // window, so a match is seen in the same cycle as the last sync bit.
    // The low bits of the window double as the nibble packer because the
    // payload is shifted through the same history register.
    always_comb begin
        window        = {sr, rx_serial_data};
        match         = (window == SYNC_WORD);
        at_sync_end   = (bit_cnt == LAST_BIT);
        at_nibble_end = (bit_cnt < PAYLOAD_END) && (bit_cnt[1:0] == 2'b11);
        bit_cnt_inc   = at_sync_end ? '0 : bit_cnt + CNT_W'(1);
        hits_inc      = hits + 4'd1;
        miss_inc      = miss + 4'd1;
    end

    // Next-state and registered-output logic. align_en low takes effect
    // whether or not a bit is present, so a disabled aligner drops lock on
    // the next clock and any partially assembled nibble is simply never
    // emitted. Without a valid bit nothing else moves and no strobe fires.
    // A failed check in VERIFY returns to HUNT without re-examining the
    // current window; the next valid bit starts a fresh search.
    always_comb begin
        state_next        = state;
        sr_next           = sr;
        bit_cnt_next      = bit_cnt;
        hits_next         = hits;
        miss_next         = miss;
        nibble_next       = rx_nibble;
        nibble_valid_next = 1'b0;
        sync_miss_next    = 1'b0;
        err_cnt_next      = sync_err_cnt;

        if (!align_en) begin
            state_next   = ALIGN_HUNT;
            bit_cnt_next = '0;
            hits_next    = '0;
            miss_next    = '0;
            if (rx_serial_valid) begin
                sr_next = window[SYNC_W-2:0];
            end
        end else if (rx_serial_valid) begin
            sr_next = window[SYNC_W-2:0];
            case (state)
                ALIGN_HUNT: begin
                    if (match) begin
                        state_next   = ALIGN_VERIFY;
                        hits_next    = 4'd1;
                        bit_cnt_next = '0;
                    end
                end

                ALIGN_VERIFY: begin
                    bit_cnt_next = bit_cnt_inc;
                    if (at_sync_end) begin
                        if (match) begin
                            hits_next = hits_inc;
                            if (hits_inc >= LOCK_HITS_C) begin
                                state_next = ALIGN_LOCKED;
                                miss_next  = '0;
                            end
                        end else begin
                            state_next   = ALIGN_HUNT;
                            hits_next    = '0;
                            bit_cnt_next = '0;
                        end
                    end
                end

                ALIGN_LOCKED: begin
                    bit_cnt_next = bit_cnt_inc;
                    if (at_nibble_end) begin
                        nibble_next       = window[NIBBLE_W-1:0];
                        nibble_valid_next = 1'b1;
                    end
                    // Frame timing is kept across misses; only the miss
                    // budget running out sends the aligner back to HUNT.
                    if (at_sync_end) begin
                        if (match) begin
                            miss_next = '0;
                        end else begin
                            sync_miss_next = 1'b1;
                            if (sync_err_cnt != {ERR_CNT_W{1'b1}}) begin
                                err_cnt_next = sync_err_cnt + ERR_CNT_W'(1);
                            end
                            if (miss_inc >= MISS_LIMIT_C) begin
                                state_next   = ALIGN_HUNT;
                                miss_next    = '0;
                                hits_next    = '0;
                                bit_cnt_next = '0;
                            end else begin
                                miss_next = miss_inc;
                            end
                        end
                    end
                end

                default: begin
                    state_next = ALIGN_HUNT;
                end
            endcase
        end

        aligned_next = (state_next == ALIGN_LOCKED);
    end

    // State and output registers; rst and align_rst share one clear path.
    always_ff @(posedge clk_240m_rx) begin
        if (rst || align_rst) begin
            state           <= ALIGN_HUNT;
            sr              <= '0;
            bit_cnt         <= '0;
            hits            <= '0;
            miss            <= '0;
            rx_nibble       <= '0;
            rx_nibble_valid <= 1'b0;
            rx_aligned      <= 1'b0;
            sync_miss       <= 1'b0;
            sync_err_cnt    <= '0;
        end else begin
            state           <= state_next;
            sr              <= sr_next;
            bit_cnt         <= bit_cnt_next;
            hits            <= hits_next;
            miss            <= miss_next;
            rx_nibble       <= nibble_next;
            rx_nibble_valid <= nibble_valid_next;
            rx_aligned      <= aligned_next;
            sync_miss       <= sync_miss_next;
            sync_err_cnt    <= err_cnt_next;
        end
    end

endmodule
